// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared types and limits for the LC3 memory-access controller.
package lc3_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_IND    = 2'd2,
        MEM_DONE   = 2'd3
    } mem_state_t;

    localparam int MEM_WAIT_MAX = 15;

    // Width of a counter that must hold 0..wait_cyc.
    function automatic int wait_ctr_w(input int wait_cyc);
        return $clog2(wait_cyc + 1);
    endfunction

endpackage

// File: rtl/lc3_wait_ctr.sv
// RAM wait-cycle counter: clear/enable with a decode of the final and
// second-to-final access cycle.
module lc3_wait_ctr
    import lc3_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int CW       = wait_ctr_w(WAIT_CYC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last,
    output logic          pre_last
);

    localparam int PRE = (WAIT_CYC >= 2) ? WAIT_CYC - 2 : 0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last     = (cnt == CW'(WAIT_CYC - 1));
    // pre_last lets the FSM register the write strobe one cycle ahead.
    assign pre_last = (WAIT_CYC >= 2) && (cnt == CW'(PRE));

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC3 memory-access controller: one request per handshake, MAR/MDR held for
// WAIT_CYC RAM cycles. Indirect (LDI/STI) accesses built with LC3_MEM_INDIRECT_EN.
module lc3_mem_ctrl
    import lc3_mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_ind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW       = wait_ctr_w(WAIT_CYC);
    localparam bit ONE_CYC  = (WAIT_CYC == 1);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; the requester holds req_* stable until then.
    mem_state_t        state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              we_r;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              pre_last;
    logic              ind_now;

`ifdef LC3_MEM_INDIRECT_EN
    logic ind_ph;
    assign ind_now = ind_ph;
`else
    logic unused_ind;
    assign unused_ind = req_ind;
    assign ind_now    = 1'b0;
`endif

    lc3_wait_ctr #(.WAIT_CYC(WAIT_CYC), .CW(CW)) u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state != MEM_ACCESS) || last),
        .en       ((state == MEM_ACCESS) && !last),
        .cnt      (cnt),
        .last     (last),
        .pre_last (pre_last)
    );

    assign mem_addr  = mar;
    assign mem_wdata = mdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MEM_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mar       <= '0;
            mdr       <= '0;
            we_r      <= 1'b0;
`ifdef LC3_MEM_INDIRECT_EN
            ind_ph    <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (req_valid) begin
                        mar       <= req_addr;
                        mdr       <= req_wdata;
                        we_r      <= req_we;
                        mem_en    <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= MEM_ACCESS;
`ifdef LC3_MEM_INDIRECT_EN
                        ind_ph    <= req_ind;
                        mem_we    <= ONE_CYC && req_we && !req_ind;
`else
                        mem_we    <= ONE_CYC && req_we;
`endif
                    end
                end
                MEM_ACCESS: begin
                    if (last) begin
                        mem_en <= 1'b0;
`ifdef LC3_MEM_INDIRECT_EN
                        if (ind_ph) begin
                            // Pointer fetched: it becomes the data address.
                            mar    <= ADDR_W'(mem_rdata);
                            ind_ph <= 1'b0;
                            state  <= MEM_IND;
                        end else
`endif
                        begin
                            if (!we_r) begin
                                mdr <= mem_rdata;
                            end
                            rsp_valid <= 1'b1;
                            rsp_rdata <= we_r ? mdr : mem_rdata;
                            state     <= MEM_DONE;
                        end
                    end else begin
                        mem_we <= pre_last && we_r && !ind_now;
                    end
                end
`ifdef LC3_MEM_INDIRECT_EN
                MEM_IND: begin
                    mem_en <= 1'b1;
                    mem_we <= ONE_CYC && we_r;
                    state  <= MEM_ACCESS;
                end
`endif
                MEM_DONE: begin
                    req_ready <= 1'b1;
                    state     <= MEM_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    state     <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: timeline-based reference model, directed literal
// checks, randomized traffic, and a WAIT_CYC=1 instance.
module tb_lc3_mem_ctrl;

    localparam int W = 2;

`ifdef LC3_MEM_INDIRECT_EN
    localparam bit IND_EN = 1'b1;
`else
    localparam bit IND_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic do_init = 1'b1;
    logic chk_on = 1'b0;
    always #5 clk = ~clk;

    // main DUT (WAIT_CYC=2)
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_ind = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, mem_en, mem_we;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(W)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_ind(req_ind),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // second DUT (WAIT_CYC=1)
    logic        req_valid1 = 1'b0, req_ready1, req_we1 = 1'b0, req_ind1 = 1'b0;
    logic [15:0] req_addr1 = '0, req_wdata1 = '0;
    logic        rsp_valid1, mem_en1, mem_we1;
    logic [15:0] rsp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1), .req_ind(req_ind1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    // RAM models seen by the DUTs
    logic [15:0] ram  [0:65535];
    logic [15:0] ram1 [0:65535];
    assign mem_rdata  = ram[mem_addr];
    assign mem_rdata1 = ram1[mem_addr1];

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 16'h0000;
            ram[16'h3000] <= 16'h1234;
            ram[16'h4000] <= 16'h3000;
            for (int i = 1; i < 4; i++) ram[16'h4000 + i] <= 16'h3000 + 16'(i);
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 65536; i++) ram1[i] <= 16'h0000;
            ram1[16'h3000] <= 16'h1234;
        end else if (mem_en1 && mem_we1) begin
            ram1[mem_addr1] <= mem_wdata1;
        end
    end

    // scoreboard counters
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, described by its phase k
    // (cycles since acceptance); all outputs follow from the access timeline.
    logic [15:0] ref_mem [0:65535];
    bit          busy = 1'b0;
    int          k = 0;
    bit          m_we, m_ind;
    logic [15:0] m_a, m_d, m_p;

    function automatic int fin_ph(input bit ind);
        return ind ? 2 * W + 2 : W + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (do_init) begin
            for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0000;
            ref_mem[16'h3000] = 16'h1234;
            ref_mem[16'h4000] = 16'h3000;
            for (int i = 1; i < 4; i++) ref_mem[16'h4000 + i] = 16'h3000 + 16'(i);
            busy = 1'b0;
            k    = 0;
        end else if (rst) begin
            busy = 1'b0;
            k    = 0;
        end else if (!busy) begin
            if (req_valid) begin
                busy  = 1'b1;
                k     = 1;
                m_we  = req_we;
                m_ind = req_ind && IND_EN;
                m_a   = req_addr;
                m_d   = req_wdata;
                m_p   = ref_mem[req_addr];
            end
        end else if (k == fin_ph(m_ind)) begin
            busy = 1'b0;
            k    = 0;
        end else begin
            k++;
            if (k == fin_ph(m_ind) && m_we) ref_mem[m_ind ? m_p : m_a] = m_d;
        end
    end

    // compare process: every cycle outside reset
    always @(negedge clk) begin
        logic        e_en, e_we, e_rsp;
        logic [15:0] e_addr, e_rd;
        if (chk_on && !rst) begin
            e_en = 1'b0; e_we = 1'b0; e_rsp = 1'b0; e_addr = '0; e_rd = '0;
            if (busy) begin
                if (!m_ind) begin
                    if (k <= W) begin
                        e_en = 1'b1; e_addr = m_a; e_we = m_we && (k == W);
                    end else begin
                        e_rsp = 1'b1; e_rd = m_we ? m_d : ref_mem[m_a];
                    end
                end else begin
                    if (k <= W) begin
                        e_en = 1'b1; e_addr = m_a;
                    end else if (k >= W + 2 && k <= 2 * W + 1) begin
                        e_en = 1'b1; e_addr = m_p; e_we = m_we && (k == 2 * W + 1);
                    end else if (k == 2 * W + 2) begin
                        e_rsp = 1'b1; e_rd = m_we ? m_d : ref_mem[m_p];
                    end
                end
            end
            chk("req_ready", req_ready, !busy);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("rsp_valid", rsp_valid, e_rsp);
            if (e_en) chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, m_d);
            if (e_rsp) chk("rsp_rdata", rsp_rdata, e_rd);
        end
    end

    // driver: called at a negedge, returns at the negedge after acceptance
    task automatic drive(input bit we, input bit ind, input logic [15:0] a, input logic [15:0] d);
        bit acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_ind = ind; req_addr = a; req_wdata = d;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = req_ready;
            @(negedge clk);
        end
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got not-ready expected accept at %0t", $time);
        end
    endtask

    task automatic drive1(input bit we, input logic [15:0] a, input logic [15:0] d);
        bit acc = 1'b0;
        req_valid1 = 1'b1; req_we1 = we; req_ind1 = 1'b0; req_addr1 = a; req_wdata1 = d;
        for (int i = 0; i < 60 && !acc; i++) begin
            acc = req_ready1;
            @(negedge clk);
        end
        req_valid1 = 1'b0;
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL accept1_timeout: got not-ready expected accept at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(posedge clk);
        #1;
        do_init = 1'b0;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // direct read of 0x3000
        drive(1'b0, 1'b0, 16'h3000, 16'h0000);
        req_valid = 1'b0;
        chk("rd_c1_en", mem_en, 1'b1);
        chk("rd_c1_addr", mem_addr, 16'h3000);
        @(negedge clk);
        chk("rd_c2_addr", mem_addr, 16'h3000);
        @(negedge clk);
        chk("rd_c3_rsp", rsp_valid, 1'b1);
        chk("rd_c3_data", rsp_rdata, 16'h1234);
        idle(1);

        // write 0xBEEF to 0x3001, then read it back
        drive(1'b1, 1'b0, 16'h3001, 16'hBEEF);
        req_valid = 1'b0;
        chk("wr_c1_we", mem_we, 1'b0);
        @(negedge clk);
        chk("wr_c2_we", mem_we, 1'b1);
        @(negedge clk);
        chk("wr_c3_we", mem_we, 1'b0);
        chk("wr_c3_data", rsp_rdata, 16'hBEEF);
        idle(1);
        drive(1'b0, 1'b0, 16'h3001, 16'h0000);
        idle(2);
        chk("rdback_data", rsp_rdata, 16'hBEEF);
        idle(1);

        // indirect read of 0x4000
        drive(1'b0, 1'b1, 16'h4000, 16'h0000);
        req_valid = 1'b0;
        chk("ind_c1_addr", mem_addr, 16'h4000);
        @(negedge clk);
        @(negedge clk);
`ifdef LC3_MEM_INDIRECT_EN
        chk("ind_c3_en", mem_en, 1'b0);
        @(negedge clk);
        chk("ind_c4_addr", mem_addr, 16'h3000);
        @(negedge clk);
        @(negedge clk);
        chk("ind_c6_data", rsp_rdata, 16'h1234);
`else
        chk("ind_c3_data", rsp_rdata, 16'h3000);
`endif
        idle(2);

        // two back-to-back requests with req_valid held high
        drive(1'b0, 1'b0, 16'h3000, 16'h0000);
        req_addr = 16'h3001;
        chk("b2b_c1_ready", req_ready, 1'b0);
        @(negedge clk);
        chk("b2b_c2_ready", req_ready, 1'b0);
        @(negedge clk);
        chk("b2b_c3_ready", req_ready, 1'b0);
        @(negedge clk);
        chk("b2b_c4_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_c5_addr", mem_addr, 16'h3001);
        idle(4);

        // reset during cycle 2 of a write
        drive(1'b1, 1'b0, 16'h3002, 16'h5555);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_en", mem_en, 1'b0);
        chk("rstmid_we", mem_we, 1'b0);
        chk("rstmid_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", req_ready, 1'b1);
        chk("rstmid_ram", ram[16'h3002], 16'h0000);
        idle(2);

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            logic [15:0] a;
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            if ($urandom_range(0, 2) == 0) a = 16'h4000 + 16'($urandom_range(0, 3));
            else a = 16'h3000 + 16'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        idle(2 * W + 4);
        for (int i = 0; i < 8; i++) chk("ram_final", ram[16'h3000 + i], ref_mem[16'h3000 + i]);

        // WAIT_CYC=1 instance
        drive1(1'b0, 16'h3000, 16'h0000);
        chk("w1_c1_en", mem_en1, 1'b1);
        chk("w1_c1_addr", mem_addr1, 16'h3000);
        chk("w1_c1_rsp", rsp_valid1, 1'b0);
        @(negedge clk);
        chk("w1_c2_en", mem_en1, 1'b0);
        chk("w1_c2_rsp", rsp_valid1, 1'b1);
        chk("w1_c2_data", rsp_rdata1, 16'h1234);
        @(negedge clk);
        chk("w1_c3_ready", req_ready1, 1'b1);
        drive1(1'b1, 16'h3005, 16'h7777);
        chk("w1_wr_c1_we", mem_we1, 1'b1);
        @(negedge clk);
        chk("w1_wr_c2_we", mem_we1, 1'b0);
        chk("w1_wr_c2_data", rsp_rdata1, 16'h7777);
        @(negedge clk);
        chk("w1_wr_ram", ram1[16'h3005], 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
